// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 stream multiplexer with valid/ready on every channel.
// Round-robin or fixed-priority arbitration, optional packet locking, and one
// registered output stage that sustains one beat per cycle.
//
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : per-channel beat valid
//   in_data    : channel i at [i*WIDTH +: WIDTH]
//   in_last    : per-channel end-of-packet flag
//   in_ready   : per-channel accept (combinational, at most one high)
//   out_valid  : output beat valid
//   out_data   : output beat data
//   out_last   : end-of-packet flag of the output beat
//   out_ch     : source channel of the output beat
//   out_ready  : consumer accept
module rr_stream_mux #(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int RR_MODE  = 1,
  parameter int LOCK_PKT = 0,
  localparam int CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr, ptr_nxt;
  logic [CH_W-1:0]   lock_ch, lock_ch_nxt;
  logic [CH_W-1:0]   win, sel_ch;
  logic              win_vld;
  logic [NUM_CH-1:0] grant;
  logic              load_en, xfer_any, sel_last;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Output register is free when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Circular search starting at the pointer; fixed priority starts at 0.
  always_comb begin
    logic [CH_W-1:0] base;
    logic [CH_W-1:0] cand;
    int              idx;
    win     = '0;
    win_vld = 1'b0;
    base    = (RR_MODE != 0) ? ptr : '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = int'(base) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!win_vld && in_valid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // While locked the grant stays on the locked channel even if it idles,
  // so no other channel can interleave into the packet.
  always_comb begin
    grant  = '0;
    sel_ch = win;
    if (state == LOCKED) begin
      sel_ch        = lock_ch;
      grant[lock_ch] = 1'b1;
    end else if (win_vld) begin
      grant[win] = 1'b1;
    end
  end

  assign in_ready = (rst || !load_en) ? '0 : grant;
  assign xfer_any = |(in_valid & in_ready);
  assign sel_last = in_last[sel_ch];

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    ptr_nxt     = ptr;
    if (xfer_any) begin
      if (RR_MODE != 0)
        ptr_nxt = (sel_ch == CH_W'(NUM_CH-1)) ? '0 : sel_ch + 1'b1;
      if (LOCK_PKT != 0) begin
        case (state)
          IDLE: if (!sel_last) begin
            state_nxt   = LOCKED;
            lock_ch_nxt = sel_ch;
          end
          LOCKED: if (sel_last) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_ch   <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      ptr     <= ptr_nxt;
      if (load_en) begin
        out_valid <= xfer_any;
        if (xfer_any) begin
          out_data <= ch_data[sel_ch];
          out_last <= sel_last;
          out_ch   <= sel_ch;
        end
      end
    end
  end

endmodule
